// File: rtl/lfsr_pkg.sv
// lfsr_pkg: shared helpers and constants for the paged LFSR LED display.
//   clog2      ceiling log2 (returns 0 for values <= 1)
//   num_pages  number of LED pages needed to show a WIDTH-bit state
//   page_w     page select width, never narrower than 1 bit
//   TAPS_Wn    maximal-length feedback masks for common widths
//              (bit i set = state[i] takes part in the XOR feedback)
package lfsr_pkg;

  localparam logic [7:0]  TAPS_W8  = 8'hB8;
  localparam logic [15:0] TAPS_W16 = 16'hB400;
  localparam logic [21:0] TAPS_W22 = 22'h300000;
  localparam logic [31:0] TAPS_W32 = 32'h80200003;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

  function automatic int num_pages(input int width, input int led_w);
    return (width + led_w - 1) / led_w;
  endfunction

  function automatic int page_w(input int width, input int led_w);
    int n;
    n = clog2(num_pages(width, led_w));
    return (n < 1) ? 1 : n;
  endfunction

endpackage

// File: rtl/lfsr_led_pager_if.sv
// lfsr_led_pager_if: control and display bundle of lfsr_led_pager.
//   run           1 = prescaler counts and LFSR steps
//   load          1-cycle strobe, captures seed into the LFSR
//   seed          WIDTH-bit value captured on load
//   page          page select, page_w(WIDTH, LED_W) bits
//   led           selected LED page (registered)
//   led_max_tick  high while the LFSR sits on its start value (registered)
//   lfsr_q        current LFSR state
//   step_o        1-cycle pulse in the cycle the LFSR advances
// Modports: master drives the controls, slave is the generator.
interface lfsr_led_pager_if
  import lfsr_pkg::*;
#(
  parameter int WIDTH = 22,
  parameter int LED_W = 14
);
  localparam int PW = page_w(WIDTH, LED_W);

  logic             run;
  logic             load;
  logic [WIDTH-1:0] seed;
  logic [PW-1:0]    page;
  logic [LED_W-1:0] led;
  logic             led_max_tick;
  logic [WIDTH-1:0] lfsr_q;
  logic             step_o;

  modport master (
    output run, load, seed, page,
    input  led, led_max_tick, lfsr_q, step_o
  );

  modport slave (
    input  run, load, seed, page,
    output led, led_max_tick, lfsr_q, step_o
  );

endinterface

// File: rtl/lfsr_core.sv
// lfsr_core: Fibonacci LFSR register with step, load and optional lock-up guard.
//   clk      system clock
//   reset    asynchronous, active-low reset (state and start -> SEED)
//   i_step   advance one position this cycle
//   i_load   capture i_seed as both state and start value (wins over i_step)
//   i_seed   value captured on i_load
//   o_q      current LFSR state
//   o_start  start value the state is compared against for the wrap flag
// Build option: LFSR_LOCKUP_GUARD_EN defined -> the all-zero state is replaced by
// SEED both when stepping out of it and when it is loaded.
module lfsr_core #(
  parameter int               WIDTH = 22,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(22'h300000),
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_step,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_seed,
  output logic [WIDTH-1:0] o_q,
  output logic [WIDTH-1:0] o_start
);

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_start;
  logic             w_fb;
  logic [WIDTH-1:0] w_shift;
  logic [WIDTH-1:0] w_step_val;
  logic [WIDTH-1:0] w_load_val;

  always_comb begin
    w_fb    = ^(r_q & TAPS);
    w_shift = {r_q[WIDTH-2:0], w_fb};
`ifdef LFSR_LOCKUP_GUARD_EN
    // Zero is a fixed point of a pure XOR LFSR; escape it through SEED.
    w_step_val = (r_q == '0) ? SEED : w_shift;
    w_load_val = (i_seed == '0) ? SEED : i_seed;
`else
    w_step_val = w_shift;
    w_load_val = i_seed;
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_q     <= SEED;
      r_start <= SEED;
    end else if (i_load) begin
      r_q     <= w_load_val;
      r_start <= w_load_val;
    end else if (i_step) begin
      r_q     <= w_step_val;
    end
  end

  assign o_q     = r_q;
  assign o_start = r_start;

endmodule

// File: rtl/lfsr_led_pager.sv
// lfsr_led_pager: LFSR pattern generator with paged LED display for demo boards.
//   clk    system clock (single clock domain, no derived clocks)
//   reset  asynchronous, active-low reset
//   bus    lfsr_led_pager_if.slave: run/load/seed/page in; led, led_max_tick,
//          lfsr_q, step_o out
// The LFSR advances once every DIV clk cycles while run is high, driven by an
// internal prescaler strobe. Page p shows lfsr_q[p*LED_W +: LED_W]; bits beyond
// the state width and pages beyond the last one read as zero.
// Build option: LFSR_LOCKUP_GUARD_EN (see lfsr_core); ports are identical either way.
module lfsr_led_pager
  import lfsr_pkg::*;
#(
  parameter int               WIDTH = 22,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(TAPS_W22),
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(1),
  parameter int               LED_W = 14,
  parameter int               DIV   = 100_000_000
) (
  input  logic             clk,
  input  logic             reset,
  lfsr_led_pager_if.slave  bus
);

  localparam int NUM_PAGES = num_pages(WIDTH, LED_W);
  localparam int EXT_W     = NUM_PAGES * LED_W;
  localparam int CNT_W     = clog2(DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_step;
  logic [LED_W-1:0] r_led;
  logic             r_max;
  logic             w_wrap;
  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_start;
  logic [EXT_W-1:0] w_ext;
  logic [LED_W-1:0] w_led_nxt;

  // A load in the wrap cycle takes priority and swallows that step.
  assign w_wrap = bus.run && (r_cnt == CNT_MAX) && !bus.load;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt  <= '0;
      r_step <= 1'b0;
    end else begin
      r_step <= w_wrap;
      if (bus.load) begin
        r_cnt <= '0;
      end else if (bus.run) begin
        r_cnt <= (r_cnt == CNT_MAX) ? '0 : r_cnt + CNT_W'(1);
      end
    end
  end

  lfsr_core #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS),
    .SEED  (SEED)
  ) u_core (
    .clk     (clk),
    .reset   (reset),
    .i_step  (w_wrap),
    .i_load  (bus.load),
    .i_seed  (bus.seed),
    .o_q     (w_q),
    .o_start (w_start)
  );

  // Zero-pad the state to whole pages so the last page reads 0 above WIDTH-1.
  assign w_ext = EXT_W'(w_q);

  always_comb begin
    w_led_nxt = '0;
    for (int p = 0; p < NUM_PAGES; p++) begin
      if (int'(bus.page) == p) begin
        w_led_nxt = w_ext[p*LED_W +: LED_W];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_led <= '0;
      r_max <= 1'b0;
    end else begin
      r_led <= w_led_nxt;
      r_max <= (w_q == w_start);
    end
  end

  assign bus.led          = r_led;
  assign bus.led_max_tick = r_max;
  assign bus.lfsr_q       = w_q;
  assign bus.step_o       = r_step;

endmodule
